// File: rtl/chess_pkg.sv
// Shared definitions for the move-generation / move-collection datapath.
// Holds the piece and colour codes used by the square units, the move-word
// flag positions, the invalid-move constant and the move and FIFO widths.
package chess_pkg;

  localparam int unsigned MV_W      = 19;
  localparam int unsigned ENTRY_W   = 160;
  localparam int unsigned N_SLOTS   = 8;
  localparam int unsigned SLOT_BITS = N_SLOTS * MV_W;   // 152; bits above are padding

  typedef enum logic [2:0] {
    PC_NONE   = 3'd0,
    PC_PAWN   = 3'd1,
    PC_KNIGHT = 3'd2,
    PC_BISHOP = 3'd3,
    PC_ROOK   = 3'd4,
    PC_QUEEN  = 3'd5,
    PC_KING   = 3'd6
  } piece_e;

  typedef enum logic {
    CL_WHITE = 1'b0,
    CL_BLACK = 1'b1
  } colour_e;

  // Move-word flag bit positions
  localparam int unsigned MF_INVALID = 18;
  localparam int unsigned MF_PROMOTE = 17;
  localparam int unsigned MF_PAWN_MV = 16;
  localparam int unsigned MF_PAWN2   = 15;
  localparam int unsigned MF_EP      = 14;
  localparam int unsigned MF_CASTLE  = 13;
  localparam int unsigned MF_CAPTURE = 12;

  // Invalid-move word written by square units into unused move slots
  localparam logic [MV_W-1:0] IMOV = {1'b1, {(MV_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_READ   = 3'd3,
    ST_UNPACK = 3'd4,
    ST_FINISH = 3'd5
  } mc_state_e;

endpackage

// File: rtl/move_slot_pick.sv
// Priority picker over the eight move slots of one FIFO entry.
//   mask_i : per-slot "still to be emitted" flags
//   idx_o  : index of the highest set bit (slot 7 has priority)
//   any_o  : at least one bit of mask_i is set
module move_slot_pick (
  input  logic [7:0] mask_i,
  output logic [2:0] idx_o,
  output logic       any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |mask_i;
    // Ascending scan, so the highest set bit is the last one written
    for (int unsigned i = 0; i < 8; i++) begin
      if (mask_i[i]) idx_o = i[2:0];
    end
  end

endmodule

// File: rtl/move_collector.sv
// Drains the per-square move FIFOs once every square unit reports done,
// unpacks each 160-bit entry into eight 19-bit slots and streams the valid
// moves one per cycle over a valid/ready handshake.
//   clk, reset          : clock, asynchronous active-high reset
//   start               : one-cycle pulse starting a pass (honoured in IDLE only)
//   sq_done, sq_empty   : per-square done and FIFO-empty flags
//   sq_rden, sq_sel     : one-hot FIFO read strobe and external data-mux select
//   sq_data             : selected FIFO output, valid the cycle after sq_rden
//   mv_valid/mv_data/mv_ready : outgoing move stream
//   mv_count            : saturating count of moves accepted this pass
//   busy, list_done     : not idle / pass complete (held until next start)
module move_collector
  import chess_pkg::*;
#(
  parameter int unsigned N_SQ  = 64,
  parameter int unsigned SQ_W  = 6,
  parameter int unsigned CNT_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_SQ-1:0]    sq_done,
  input  logic [N_SQ-1:0]    sq_empty,
  output logic [N_SQ-1:0]    sq_rden,
  output logic [SQ_W-1:0]    sq_sel,
  input  logic [ENTRY_W-1:0] sq_data,
  output logic               mv_valid,
  output logic [MV_W-1:0]    mv_data,
  input  logic               mv_ready,
  output logic [CNT_W-1:0]   mv_count,
  output logic               busy,
  output logic               list_done
);

  mc_state_e            state_q, state_d;
  logic [SQ_W-1:0]      sel_q, sel_d;
  logic [SLOT_BITS-1:0] slots_q, slots_d;
  logic [N_SLOTS-1:0]   mask_q, mask_d, mask_eff;
  logic [2:0]           idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic [MV_W-1:0]      data_q, data_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 hshake;
  logic [2:0]           pick_idx;
  logic                 pick_any;
  logic                 unused_pad;

  assign unused_pad = ^sq_data[ENTRY_W-1:SLOT_BITS];
  assign hshake     = valid_q & mv_ready;

  // Mask as it will be after the current handshake; the picker looks at
  // this so the next slot can be presented back-to-back.
  always_comb begin
    mask_eff = mask_q;
    if (hshake) mask_eff[idx_q] = 1'b0;
  end

  move_slot_pick u_pick (
    .mask_i (mask_eff),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      slots_q <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      slots_q <= slots_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    slots_d = slots_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    sq_rden = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (&sq_done) begin
          sel_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!sq_empty[sel_q]) begin
          sq_rden[sel_q] = 1'b1;
          state_d        = ST_READ;
        end else if (sel_q == SQ_W'(N_SQ - 1)) begin
          state_d = ST_FINISH;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
      ST_READ: begin
        slots_d = sq_data[SLOT_BITS-1:0];
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
          mask_d[i] = ~sq_data[MV_W*i + MF_INVALID];
        end
        state_d = ST_UNPACK;
      end
      ST_UNPACK: begin
        // A presented move is held untouched until it is accepted
        if (!(valid_q && !mv_ready)) begin
          if (hshake && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
          mask_d = mask_eff;
          if (pick_any) begin
            valid_d = 1'b1;
            idx_d   = pick_idx;
            data_d  = slots_q[int'(pick_idx)*MV_W +: MV_W];
          end else begin
            valid_d = 1'b0;
            state_d = ST_SCAN;
          end
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sq_sel    = sel_q;
  assign mv_valid  = valid_q;
  assign mv_data   = data_q;
  assign mv_count  = cnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign list_done = done_q;

endmodule

// File: tb/tb_move_collector.sv
module tb_move_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [63:0]  sq_done;
  logic [63:0]  sq_empty = '1;
  logic [63:0]  sq_rden;
  logic [5:0]   sq_sel;
  logic [159:0] sq_data = '0;
  logic         mv_valid;
  logic [18:0]  mv_data;
  logic         mv_ready;
  logic [9:0]   mv_count;
  logic         busy;
  logic         list_done;

  logic         rnd_mode = 1'b0;
  logic         ready_force = 1'b1;
  logic         rnd_bit = 1'b1;

  int           checks = 0;
  int           errors = 0;
  int           hs_cnt = 0;
  int           rd_total = 0;
  int           rd_tot [64];

  logic [159:0] fq [64][$];
  logic [18:0]  exp_q [$];

  typedef struct {
    int unsigned sq;
    int unsigned n_ent;
    logic [7:0]  vmask;
    logic        rnd;
    int unsigned exp_count;
    int unsigned exp_rd;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  assign mv_ready = rnd_mode ? rnd_bit : ready_force;

  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  move_collector #(.N_SQ(64), .SQ_W(6), .CNT_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sq_done   (sq_done),
    .sq_empty  (sq_empty),
    .sq_rden   (sq_rden),
    .sq_sel    (sq_sel),
    .sq_data   (sq_data),
    .mv_valid  (mv_valid),
    .mv_data   (mv_data),
    .mv_ready  (mv_ready),
    .mv_count  (mv_count),
    .busy      (busy),
    .list_done (list_done)
  );

  // FIFO model: data appears the cycle after the read strobe
  always @(posedge clk) begin
    for (int i = 0; i < 64; i++) begin
      if (sq_rden[i] && fq[i].size() > 0) sq_data <= fq[i].pop_front();
    end
    for (int i = 0; i < 64; i++) sq_empty[i] <= (fq[i].size() == 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: values seen here are those present at the next rising edge
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      if (mv_valid && mv_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_move actual=%0h required=none", mv_data);
        end else begin
          chk("move_data", 64'(mv_data), 64'(exp_q.pop_front()));
        end
      end
      if (sq_rden != '0) begin
        chk("rden_onehot", 64'($countones(sq_rden)), 64'd1);
        chk("rden_on_empty", 64'(|(sq_rden & sq_empty)), 64'd0);
        chk("rden_with_valid", 64'(mv_valid), 64'd0);
        rd_total++;
        for (int i = 0; i < 64; i++) if (sq_rden[i]) rd_tot[i]++;
      end
    end
  end

  task automatic load_sq(input int unsigned sq, input int unsigned n, input logic [7:0] vm);
    logic [159:0] ent;
    logic [18:0]  mv;
    for (int unsigned e = 0; e < n; e++) begin
      ent = '0;
      ent[159:152] = 8'($urandom);
      for (int i = 7; i >= 0; i--) begin
        if (vm[i]) begin
          mv[18]    = 1'b0;
          mv[17:12] = 6'(8*e + i);
          mv[11:6]  = 6'((sq + 8*i + e) % 64);
          mv[5:0]   = 6'(sq);
          exp_q.push_back(mv);
        end else begin
          mv = {1'b1, 18'($urandom)};
        end
        ent[19*i +: 19] = mv;
      end
      fq[sq].push_back(ent);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_list_done(input string name);
    int n;
    n = 0;
    while (!list_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(list_done), 64'd1);
  endtask

  task automatic wait_hs(input int target, input string name);
    int n;
    n = 0;
    while (hs_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(hs_cnt >= target), 64'd1);
  endtask

  initial begin
    int n;
    int hs0;
    int rd0;
    int rda;
    int rdb;
    logic [18:0] held;

    vecs[0] = '{12, 1, 8'h84, 1'b0, 2, 1};
    vecs[1] = '{0, 2, 8'hFF, 1'b0, 16, 2};
    vecs[2] = '{63, 1, 8'h00, 1'b0, 0, 1};
    vecs[3] = '{33, 3, 8'h01, 1'b1, 3, 3};
    vecs[4] = '{7, 2, 8'h5A, 1'b1, 8, 2};
    vecs[5] = '{50, 1, 8'h7F, 1'b1, 7, 1};
    for (int i = 0; i < 64; i++) rd_tot[i] = 0;

    reset   = 1'b1;
    start   = 1'b0;
    sq_done = '0;
    repeat (3) @(negedge clk);
    chk("rst_rden", sq_rden, 64'd0);
    chk("rst_sel", 64'(sq_sel), 64'd0);
    chk("rst_valid", 64'(mv_valid), 64'd0);
    chk("rst_data", 64'(mv_data), 64'd0);
    chk("rst_count", 64'(mv_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(list_done), 64'd0);
    reset = 1'b0;

    // Empty board: 1 WAIT + 64 SCAN + FINISH
    sq_done = '1;
    hs0 = hs_cnt;
    rd0 = rd_total;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!list_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("empty_done_latency_ok", 64'(n >= 65 && n <= 66), 64'd1);
    chk("empty_count", 64'(mv_count), 64'd0);
    chk("empty_rden", 64'(rd_total - rd0), 64'd0);
    chk("empty_moves", 64'(hs_cnt - hs0), 64'd0);
    chk("empty_busy", 64'(busy), 64'd0);

    // Table-driven passes: one loaded square each
    for (int v = 0; v < 6; v++) begin
      rd0 = rd_tot[vecs[v].sq];
      rda = rd_total;
      load_sq(vecs[v].sq, vecs[v].n_ent, vecs[v].vmask);
      rnd_mode    = vecs[v].rnd;
      ready_force = 1'b1;
      repeat (2) @(negedge clk);
      do_start();
      wait_list_done("vec_list_done");
      chk("vec_count", 64'(mv_count), 64'(vecs[v].exp_count));
      chk("vec_rd_sq", 64'(rd_tot[vecs[v].sq] - rd0), 64'(vecs[v].exp_rd));
      chk("vec_rd_all", 64'(rd_total - rda), 64'(vecs[v].exp_rd));
      chk("vec_sb_left", 64'(exp_q.size()), 64'd0);
      chk("vec_busy", 64'(busy), 64'd0);
    end
    rnd_mode    = 1'b0;
    ready_force = 1'b1;

    // Backpressure: stall 5 cycles after the third accepted move
    load_sq(20, 1, 8'hFF);
    repeat (2) @(negedge clk);
    hs0 = hs_cnt;
    do_start();
    wait_hs(hs0 + 3, "bp_reach");
    ready_force = 1'b0;
    held = exp_q[0];
    #2;
    chk("bp_count0", 64'(mv_count), 64'd3);
    repeat (5) begin
      @(negedge clk);
      #2;
      chk("bp_valid", 64'(mv_valid), 64'd1);
      chk("bp_data", 64'(mv_data), 64'(held));
      chk("bp_count", 64'(mv_count), 64'd3);
      chk("bp_rden", sq_rden, 64'd0);
    end
    @(negedge clk);
    ready_force = 1'b1;
    wait_list_done("bp_list_done");
    chk("bp_final_count", 64'(mv_count), 64'd8);
    chk("bp_sb_left", 64'(exp_q.size()), 64'd0);

    // Square 40 not done for 20 cycles: stay in WAIT
    load_sq(40, 1, 8'h81);
    sq_done = '1;
    sq_done[40] = 1'b0;
    repeat (2) @(negedge clk);
    do_start();
    repeat (20) begin
      @(negedge clk);
      #1;
      chk("wait_rden", sq_rden, 64'd0);
      chk("wait_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    sq_done[40] = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      #1;
      if (sq_rden != '0) break;
    end
    chk("wait_scan_cycles", 64'(n), 64'd41);
    chk("wait_rden_sq40", sq_rden, 64'd1 << 40);
    wait_list_done("wait_list_done");
    chk("wait_count", 64'(mv_count), 64'd2);

    // Reset during UNPACK of square 5, then a fresh pass
    load_sq(5, 1, 8'hFF);
    repeat (2) @(negedge clk);
    hs0 = hs_cnt;
    do_start();
    wait_hs(hs0 + 2, "rst_reach_unpack");
    reset = 1'b1;
    #1;
    chk("midrst_rden", sq_rden, 64'd0);
    chk("midrst_valid", 64'(mv_valid), 64'd0);
    chk("midrst_data", 64'(mv_data), 64'd0);
    chk("midrst_count", 64'(mv_count), 64'd0);
    chk("midrst_done", 64'(list_done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_sel", 64'(sq_sel), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    load_sq(9, 1, 8'h0F);
    rda = rd_tot[9];
    rdb = rd_tot[5];
    repeat (2) @(negedge clk);
    hs0 = hs_cnt;
    do_start();
    @(negedge clk);
    chk("restart_sel0", 64'(sq_sel), 64'd0);
    chk("restart_count0", 64'(mv_count), 64'd0);
    wait_hs(hs0 + 1, "restart_first_move");
    do_start();
    wait_list_done("restart_list_done");
    chk("restart_count", 64'(mv_count), 64'd4);
    chk("restart_rd9", 64'(rd_tot[9] - rda), 64'd1);
    chk("restart_rd5", 64'(rd_tot[5] - rdb), 64'd0);
    chk("restart_sb_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("restart_done_held", 64'(list_done), 64'd1);
    chk("restart_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
